// File: rtl/pc_stack.sv
// ============================================================================
// Module   : pc_stack
// Brief    : Program counter with jump, relative branch and CALL/RET backed
//            by an internal return-address stack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_stack #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INC,
    input  logic             LD,
    input  logic             BR,
    input  logic             CALL,
    input  logic             RET,
    input  logic [WIDTH-1:0] ADDR,
    input  logic [WIDTH-1:0] OFFSET,
    output logic [WIDTH-1:0] PC,
    output logic             STK_EMPTY,
    output logic             STK_FULL,
    output logic             STK_ERR
);

    localparam int             c_sp_w    = $clog2(DEPTH + 1);
    localparam int             c_ram_n   = 1 << c_sp_w;
    localparam logic [c_sp_w-1:0] c_sp_full = c_sp_w'(DEPTH);

    logic [WIDTH-1:0]  r_pc;
    logic [c_sp_w-1:0] r_sp;
    logic              r_err;
    // RAM is sized to the full SP index range so the pointer indexes it directly.
    logic [WIDTH-1:0]  r_stack [c_ram_n];

    logic [WIDTH-1:0]  w_pc_nxt;
    logic [WIDTH-1:0]  w_pc_inc;
    logic [c_sp_w-1:0] w_sp_nxt;
    logic [c_sp_w-1:0] w_sp_dec;
    logic              w_err_nxt;
    logic              w_push;

    assign w_pc_inc = r_pc + 1'b1;
    assign w_sp_dec = r_sp - 1'b1;

    // Fixed priority: RET > CALL > LD > BR > INC > hold.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_sp_nxt  = r_sp;
        w_err_nxt = r_err;
        w_push    = 1'b0;
        if (RET) begin
            if (r_sp != '0) begin
                w_pc_nxt = r_stack[w_sp_dec];
                w_sp_nxt = w_sp_dec;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (CALL) begin
            if (r_sp != c_sp_full) begin
                w_push   = 1'b1;
                w_pc_nxt = ADDR;
                w_sp_nxt = r_sp + 1'b1;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (LD) begin
            w_pc_nxt = ADDR;
        end else if (BR) begin
            w_pc_nxt = r_pc + OFFSET;
        end else if (INC) begin
            w_pc_nxt = w_pc_inc;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc  <= RESET_VAL;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_sp  <= w_sp_nxt;
            r_err <= w_err_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            r_stack[r_sp] <= w_pc_inc;
        end
    end

    assign PC        = r_pc;
    assign STK_EMPTY = (r_sp == '0);
    assign STK_FULL  = (r_sp == c_sp_full);
    assign STK_ERR   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack.sv
// ============================================================================
// Module   : tb_pc_stack
// Brief    : Directed and randomized checks of pc_stack against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             INC = 1'b0, LD = 1'b0, BR = 1'b0, CALL = 1'b0, RET = 1'b0;
    logic [WIDTH-1:0] ADDR = '0, OFFSET = '0;
    logic [WIDTH-1:0] PC;
    logic             STK_EMPTY, STK_FULL, STK_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    int m_pc;
    int m_q[$];
    bit m_err;

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
        .CLK(CLK), .RST(RST), .INC(INC), .LD(LD), .BR(BR), .CALL(CALL), .RET(RET),
        .ADDR(ADDR), .OFFSET(OFFSET), .PC(PC),
        .STK_EMPTY(STK_EMPTY), .STK_FULL(STK_FULL), .STK_ERR(STK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    32'(PC),        32'(m_pc));
        chk({tag, ".empty"}, 32'(STK_EMPTY), 32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(STK_FULL),  32'(m_q.size() == DEPTH));
        chk({tag, ".err"},   32'(STK_ERR),   32'(m_err));
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_q   = {};
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit i, l, b, c, r, input int a, o);
        if (r) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else m_err = 1'b1;
        end else if (c) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back((m_pc + 1) & MASK);
                m_pc = a;
            end else begin
                m_err = 1'b1;
            end
        end else if (l) begin
            m_pc = a;
        end else if (b) begin
            m_pc = (m_pc + o) & MASK;
        end else if (i) begin
            m_pc = (m_pc + 1) & MASK;
        end
    endtask

    // Drive one cycle of controls at the falling edge, check after the rising edge.
    task automatic op(input string tag, input bit i, l, b, c, r,
                      input int a = 0, input int o = 0);
        @(negedge CLK);
        INC = i; LD = l; BR = b; CALL = c; RET = r;
        ADDR = WIDTH'(a); OFFSET = WIDTH'(o);
        #1 chk({tag, ".comb"}, 32'(PC), 32'(m_pc));
        @(posedge CLK);
        model_step(i, l, b, c, r, a, o);
        #1 chk_model(tag);
        INC = 0; LD = 0; BR = 0; CALL = 0; RET = 0;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1 model_reset();
        chk_model(tag);
        #1 RST = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1 chk_model("reset");
        @(negedge CLK) RST = 1'b0;

        // Reset then increment, including all-ones wrap
        op("inc0", 1, 0, 0, 0, 0);
        pulse_reset("rst_mid");
        chk("rst_mid.pc_lit", 32'(PC), 32'h0);
        repeat (3) op("inc", 1, 0, 0, 0, 0);
        chk("inc3", 32'(PC), 32'h3);
        op("ld_ff", 0, 1, 0, 0, 0, 'hFF);
        op("inc_wrap", 1, 0, 0, 0, 0);
        chk("inc_wrap_lit", 32'(PC), 32'h0);

        // Jump and branch
        op("ld10", 0, 1, 0, 0, 0, 'h10);
        op("ld40", 0, 1, 0, 0, 0, 'h40);
        chk("ld40_lit", 32'(PC), 32'h40);
        op("br_m2", 0, 0, 1, 0, 0, 0, 'hFE);
        chk("br_m2_lit", 32'(PC), 32'h3E);
        op("br_p5", 0, 0, 1, 0, 0, 0, 'h05);
        chk("br_p5_lit", 32'(PC), 32'h43);
        op("ld02", 0, 1, 0, 0, 0, 'h02);
        op("br_wrap", 0, 0, 1, 0, 0, 0, 'hFC);
        chk("br_wrap_lit", 32'(PC), 32'hFE);

        // Nested call/return
        op("ld20", 0, 1, 0, 0, 0, 'h20);
        op("call80", 0, 0, 0, 1, 0, 'h80);
        op("callA0", 0, 0, 0, 1, 0, 'hA0);
        op("ret1", 0, 0, 0, 0, 1);
        chk("ret1_lit", 32'(PC), 32'h81);
        op("ret2", 0, 0, 0, 0, 1);
        chk("ret2_lit", 32'(PC), 32'h21);
        chk("ret2_empty", 32'(STK_EMPTY), 32'h1);
        chk("ret2_err", 32'(STK_ERR), 32'h0);

        // Overflow then full unwind
        op("ld10b", 0, 1, 0, 0, 0, 'h10);
        op("c1", 0, 0, 0, 1, 0, 'h11);
        op("c2", 0, 0, 0, 1, 0, 'h22);
        op("c3", 0, 0, 0, 1, 0, 'h33);
        op("c4", 0, 0, 0, 1, 0, 'h44);
        chk("full_lit", 32'(STK_FULL), 32'h1);
        op("c5_ovf", 0, 0, 0, 1, 0, 'hCC);
        chk("ovf_pc_lit", 32'(PC), 32'h44);
        chk("ovf_err_lit", 32'(STK_ERR), 32'h1);
        op("r1", 0, 0, 0, 0, 1);
        chk("r1_lit", 32'(PC), 32'h34);
        op("r2", 0, 0, 0, 0, 1);
        op("r3", 0, 0, 0, 0, 1);
        op("r4", 0, 0, 0, 0, 1);
        chk("r4_lit", 32'(PC), 32'h11);
        op("r5_unf", 0, 0, 0, 0, 1);

        // Underflow and priority
        pulse_reset("rst_unf");
        op("unf", 0, 0, 0, 0, 1);
        chk("unf_err_lit", 32'(STK_ERR), 32'h1);
        pulse_reset("rst_pri");
        op("pri_push", 0, 0, 0, 1, 0, 'h50);
        op("pri_ret", 1, 1, 0, 1, 1, 'h77);
        chk("pri_ret_lit", 32'(PC), 32'h01);
        op("pri_ld", 1, 1, 1, 0, 0, 'h33, 'h05);
        chk("pri_ld_lit", 32'(PC), 32'h33);

        // Reset while stack is populated
        op("s1", 0, 0, 0, 1, 0, 'h60);
        op("s2", 0, 0, 0, 1, 0, 'h70);
        pulse_reset("rst_stack");
        chk("rst_stack_empty", 32'(STK_EMPTY), 32'h1);

        // Back-to-back call/ret
        op("bb_c", 0, 0, 0, 1, 0, 'h90);
        op("bb_r", 0, 0, 0, 0, 1);
        chk("bb_r_lit", 32'(PC), 32'h01);

        // Randomized mix
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                pulse_reset("rnd_rst");
            end else begin
                op("rnd",
                   bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 3) == 0),
                   bit'($urandom_range(0, 3) == 0),
                   bit'($urandom_range(0, 2) == 0),
                   bit'($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, MASK)),
                   int'($urandom_range(0, MASK)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
